// File: rtl/ip2_test3_burst_ctrl.sv
// ip2_test3_burst_ctrl
// Runs a burst of back-to-back test3 DNN captures: one launch pulse per run,
// waits for the run's status_done rising edge (optionally bounded by a
// timeout), and stores both 48-bit DNN outputs plus the run index in a small
// first-word-fall-through FIFO that software drains through valid/ready.
module ip2_test3_burst_ctrl #(
   parameter int BUF_DEPTH = 4,
   parameter int RUN_W     = 8,
   parameter int TMO_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             abort,
   input  logic [RUN_W-1:0] num_runs,
   input  logic [TMO_W-1:0] gap_cycles,
   input  logic [TMO_W-1:0] timeout_cycles,
   input  logic             test3_status_done,
   input  logic [47:0]      test3_dnn_output_0,
   input  logic [47:0]      test3_dnn_output_1,
   output logic             test3_enable_re,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [95:0]      rd_data,
   output logic [RUN_W-1:0] rd_run_idx,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [RUN_W-1:0] runs_completed
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LAUNCH  = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;
   localparam logic [2:0] ST_FINISH  = 3'd5;
   localparam logic [2:0] ST_ERROR   = 3'd6;

   logic [2:0]       state;
   logic             start_d;
   logic             status_done_d;
   logic             start_re;
   logic             done_re;
   logic [RUN_W-1:0] runs_lat;
   logic [RUN_W-1:0] runs_next;
   logic [TMO_W-1:0] tmo;
   logic [TMO_W-1:0] gap_cnt;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic [95:0]      buf_data [BUF_DEPTH];
   logic [RUN_W-1:0] buf_idx  [BUF_DEPTH];

   assign start_re  = start & ~start_d;
   assign done_re   = test3_status_done & ~status_done_d;
   assign runs_next = runs_completed + RUN_W'(1);
   assign fifo_full = (count == CNT_W'(BUF_DEPTH));

   // An abort in the capture clock also suppresses that run's push.
   assign push      = enable && (state == ST_CAPTURE) && !(abort);
   assign pop       = enable && rd_valid && rd_ready;

   assign rd_valid   = (count != '0);
   // Head entry is masked while empty so outputs read zero after reset/clear.
   assign rd_data    = rd_valid ? buf_data[rd_ptr] : '0;
   assign rd_run_idx = rd_valid ? buf_idx[rd_ptr]  : '0;

   // Edge-detect registers for start and test3 status_done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_d       <= 1'b0;
         status_done_d <= 1'b0;
      end else if (!enable) begin
         start_d       <= 1'b0;
         status_done_d <= 1'b0;
      end else begin
         start_d       <= start;
         status_done_d <= test3_status_done;
      end
   end

   // Burst sequencer: launch, wait for done edge or timeout, capture, gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         runs_lat        <= '0;
         runs_completed  <= '0;
         tmo             <= '0;
         gap_cnt         <= '0;
         test3_enable_re <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_timeout     <= 1'b0;
      end else if (!enable) begin
         state           <= ST_IDLE;
         runs_lat        <= '0;
         runs_completed  <= '0;
         tmo             <= '0;
         gap_cnt         <= '0;
         test3_enable_re <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_timeout     <= 1'b0;
      end else begin
         test3_enable_re <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_re) begin
                     if (num_runs == '0) begin
                        done        <= 1'b1;
                        err_timeout <= 1'b0;
                     end else begin
                        runs_lat       <= num_runs;
                        runs_completed <= '0;
                        done           <= 1'b0;
                        err_timeout    <= 1'b0;
                        busy           <= 1'b1;
                        state          <= ST_LAUNCH;
                     end
                  end
               end
               ST_LAUNCH: begin
                  // Holding off while full is what keeps the FIFO from overflowing.
                  if (!fifo_full) begin
                     test3_enable_re <= 1'b1;
                     tmo             <= timeout_cycles;
                     state           <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (done_re) begin
                     state <= ST_CAPTURE;
                  end else if (timeout_cycles != '0) begin
                     if (tmo == TMO_W'(1)) begin
                        state <= ST_ERROR;
                     end else begin
                        tmo <= tmo - TMO_W'(1);
                     end
                  end
               end
               ST_CAPTURE: begin
                  runs_completed <= runs_next;
                  if (runs_next == runs_lat) begin
                     state <= ST_FINISH;
                  end else if (gap_cycles == '0) begin
                     state <= ST_LAUNCH;
                  end else begin
                     gap_cnt <= gap_cycles;
                     state   <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  if (gap_cnt <= TMO_W'(1)) begin
                     state <= ST_LAUNCH;
                  end else begin
                     gap_cnt <= gap_cnt - TMO_W'(1);
                  end
               end
               ST_FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               ST_ERROR: begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!enable) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= {test3_dnn_output_1, test3_dnn_output_0};
         buf_idx[wr_ptr]  <= runs_completed;
      end
   end

endmodule

// File: tb/tb_ip2_test3_burst_ctrl.sv
// tb_ip2_test3_burst_ctrl
// Scoreboard bench: a behavioural test3 responder pushes each expected FIFO
// entry when it raises status_done; a monitor pops and compares whenever the
// DUT presents an entry that is accepted.
module tb_ip2_test3_burst_ctrl;

   localparam int BUF_DEPTH = 4;
   localparam int RUN_W     = 8;
   localparam int TMO_W     = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             start;
   logic             abort;
   logic [RUN_W-1:0] num_runs;
   logic [TMO_W-1:0] gap_cycles;
   logic [TMO_W-1:0] timeout_cycles;
   logic             test3_status_done  = 1'b0;
   logic [47:0]      test3_dnn_output_0 = '0;
   logic [47:0]      test3_dnn_output_1 = '0;
   logic             test3_enable_re;
   logic             rd_valid;
   logic             rd_ready;
   logic [95:0]      rd_data;
   logic [RUN_W-1:0] rd_run_idx;
   logic             busy;
   logic             done;
   logic             err_timeout;
   logic [RUN_W-1:0] runs_completed;

   ip2_test3_burst_ctrl #(
      .BUF_DEPTH(BUF_DEPTH), .RUN_W(RUN_W), .TMO_W(TMO_W)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort),
      .num_runs(num_runs), .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
      .test3_status_done(test3_status_done),
      .test3_dnn_output_0(test3_dnn_output_0), .test3_dnn_output_1(test3_dnn_output_1),
      .test3_enable_re(test3_enable_re), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_run_idx(rd_run_idx), .busy(busy), .done(done),
      .err_timeout(err_timeout), .runs_completed(runs_completed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [95:0]      data;
      logic [RUN_W-1:0] idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t mexp;
   exp_t got;
   int   pulse_cyc[$];
   int   pulse_cnt  = 0;
   int   resp_total = 0;
   int   pops       = 0;
   int   cd         = 0;
   int   flush_seen = 0;

   int   n_vec = 0;
   int   n_err = 0;

   // stimulus-owned knobs for the responder
   bit   resp_en    = 1'b0;
   int   resp_delay = 1;
   int   burst_base = 0;
   int   flush_gen  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor plus behavioural test3 responder, sampled on the falling edge.
   always @(negedge clk) begin
      if (flush_gen != flush_seen) begin
         exp_q.delete();
         flush_seen = flush_gen;
      end
      if (rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_unexpected: got idx %0d expected no entry", rd_run_idx);
         end else begin
            got = exp_q.pop_front();
            check("rd_data", rd_data, got.data);
            check("rd_run_idx", rd_run_idx, got.idx);
         end
         pops++;
      end
      if (!resp_en) cd = 0;
      if (test3_enable_re) begin
         pulse_cnt++;
         pulse_cyc.push_back(cyc);
         test3_status_done = 1'b0;
         cd = resp_en ? resp_delay : 0;
      end else if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            test3_dnn_output_0 = {16'($urandom), 32'($urandom)};
            test3_dnn_output_1 = {16'($urandom), 32'($urandom)};
            mexp.data = {test3_dnn_output_1, test3_dnn_output_0};
            mexp.idx  = RUN_W'(resp_total - burst_base);
            exp_q.push_back(mexp);
            resp_total++;
            test3_status_done = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise start for one clock; returns just after the edge that saw start_re's effect.
   task automatic do_start(input int nr);
      num_runs   = RUN_W'(nr);
      burst_base = resp_total;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string name);
      for (int i = 0; i < max; i++) begin
         if (!busy) break;
         tick(1);
      end
      check(name, busy, 1'b0);
   endtask

   int p0, pc0, pop0, start_c, err_c, nr, gp, dl;
   bit saw_busy;

   initial begin
      reset = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
      num_runs = '0; gap_cycles = '0; timeout_cycles = '0;
      tick(3);
      check("rst_enable_re", test3_enable_re, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err_timeout, 1'b0);
      check("rst_runs", runs_completed, 0);
      reset = 1'b0;
      tick(2);

      // T1: three runs, gap 4, responder 200 clocks, always ready
      resp_en = 1'b1; resp_delay = 200; gap_cycles = 4; timeout_cycles = 1000; rd_ready = 1'b1;
      p0 = pulse_cnt; pc0 = pulse_cyc.size(); pop0 = pops; start_c = cyc;
      do_start(3);
      wait_idle(2000, "t1_idle");
      tick(4);
      check("t1_pulses", pulse_cnt - p0, 3);
      if (pulse_cyc.size() >= pc0 + 3) begin
         // start_re seen one edge after it is driven, pulse registered one edge later
         check("t1_first_latency", pulse_cyc[pc0] - start_c, 2);
         // responder delay, then detect, capture, gap clocks, launch
         check("t1_interval1", pulse_cyc[pc0+1] - pulse_cyc[pc0], 200 + 4 + 3);
         check("t1_interval2", pulse_cyc[pc0+2] - pulse_cyc[pc0+1], 200 + 4 + 3);
      end
      check("t1_done", done, 1'b1);
      check("t1_err", err_timeout, 1'b0);
      check("t1_runs", runs_completed, 3);
      check("t1_pops", pops - pop0, 3);
      check("t1_empty", rd_valid, 1'b0);

      // T2: FIFO fills to depth and the sequencer stalls without a fifth pulse
      resp_delay = 10; gap_cycles = 2; rd_ready = 1'b0;
      p0 = pulse_cnt; pop0 = pops;
      do_start(6);
      tick(300);
      check("t2_stall_pulses", pulse_cnt - p0, BUF_DEPTH);
      check("t2_stall_busy", busy, 1'b1);
      check("t2_stall_valid", rd_valid, 1'b1);
      rd_ready = 1'b1;
      wait_idle(2000, "t2_idle");
      tick(6);
      check("t2_pulses", pulse_cnt - p0, 6);
      check("t2_runs", runs_completed, 6);
      check("t2_done", done, 1'b1);
      check("t2_pops", pops - pop0, 6);
      check("t2_sb_empty", exp_q.size(), 0);

      // T3: timeout 50 with status_done never rising
      resp_en = 1'b0; timeout_cycles = 50; gap_cycles = 0;
      p0 = pulse_cnt; pc0 = pulse_cyc.size(); err_c = -1;
      do_start(2);
      for (int i = 0; i < 200; i++) begin
         if (err_timeout) begin err_c = cyc; break; end
         tick(1);
      end
      check("t3_err", err_timeout, 1'b1);
      // the pulse clock itself, then 50 counted clocks before err_timeout shows
      if (pulse_cyc.size() > pc0) check("t3_err_time", err_c - pulse_cyc[pc0], 51);
      check("t3_busy", busy, 1'b0);
      check("t3_done", done, 1'b0);
      check("t3_empty", rd_valid, 1'b0);
      check("t3_pulses", pulse_cnt - p0, 1);

      // T4: zero runs completes at once with no launch
      p0 = pulse_cnt;
      do_start(0);
      check("t4_done", done, 1'b1);
      check("t4_err_cleared", err_timeout, 1'b0);
      saw_busy = busy;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (busy) saw_busy = 1'b1;
      end
      check("t4_never_busy", saw_busy, 1'b0);
      check("t4_pulses", pulse_cnt - p0, 0);

      // T5: async reset while waiting; start_re while busy is ignored
      resp_en = 1'b1; resp_delay = 10; timeout_cycles = 0; gap_cycles = 0; rd_ready = 1'b0;
      p0 = pulse_cnt;
      do_start(3);
      for (int i = 0; i < 100; i++) begin
         if (resp_total - burst_base >= 1) break;
         tick(1);
      end
      resp_en = 1'b0;
      tick(30);
      check("t5_busy", busy, 1'b1);
      check("t5_pulses", pulse_cnt - p0, 2);
      check("t5_valid", rd_valid, 1'b1);
      start = 1'b1; tick(1); start = 1'b0; tick(5);
      check("t5_restart_ignored", pulse_cnt - p0, 2);
      check("t5_still_busy", busy, 1'b1);
      #2;
      reset = 1'b1;
      flush_gen++;
      #1;
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_valid", rd_valid, 1'b0);
      check("t5_rst_data", rd_data, 0);
      check("t5_rst_runs", runs_completed, 0);
      check("t5_rst_done", done, 1'b0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // T6a: status_done edge lands in the timeout expiry clock
      resp_en = 1'b1; resp_delay = 49; timeout_cycles = 50; rd_ready = 1'b1;
      do_start(1);
      wait_idle(500, "t6a_idle");
      tick(3);
      check("t6a_err", err_timeout, 1'b0);
      check("t6a_done", done, 1'b1);
      check("t6a_runs", runs_completed, 1);

      // T6b: pop in the same clock as the fourth push while three are held
      resp_delay = 8; timeout_cycles = 0; rd_ready = 1'b0;
      pop0 = pops;
      do_start(4);
      for (int i = 0; i < 500; i++) begin
         if (resp_total - burst_base >= 4) break;
         tick(1);
      end
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
      tick(3);
      check("t6b_one_pop", pops - pop0, 1);
      check("t6b_valid", rd_valid, 1'b1);
      check("t6b_done", done, 1'b1);
      rd_ready = 1'b1;
      tick(8);
      check("t6b_pops", pops - pop0, 4);
      check("t6b_empty", rd_valid, 1'b0);
      check("t6b_sb_empty", exp_q.size(), 0);

      // Abort while waiting: back to idle, status flags untouched
      resp_en = 1'b0;
      p0 = pulse_cnt;
      do_start(2);
      tick(5);
      check("ab_busy", busy, 1'b1);
      abort = 1'b1; tick(1); abort = 1'b0;
      check("ab_idle", busy, 1'b0);
      check("ab_done", done, 1'b0);
      check("ab_err", err_timeout, 1'b0);
      tick(20);
      check("ab_pulses", pulse_cnt - p0, 1);

      // Randomised bursts with random back-pressure
      for (int it = 0; it < 6; it++) begin
         nr = $urandom_range(1, 6); gp = $urandom_range(0, 5); dl = $urandom_range(2, 40);
         resp_en = 1'b1; resp_delay = dl; gap_cycles = TMO_W'(gp);
         timeout_cycles = ($urandom_range(0, 1) == 0) ? '0 : TMO_W'(dl + 1 + $urandom_range(0, 20));
         p0 = pulse_cnt; pop0 = pops;
         do_start(nr);
         for (int i = 0; i < 5000; i++) begin
            if (!busy) break;
            rd_ready = 1'($urandom_range(0, 1));
            tick(1);
         end
         check("rnd_idle", busy, 1'b0);
         rd_ready = 1'b1;
         tick(10);
         check("rnd_pulses", pulse_cnt - p0, nr);
         check("rnd_runs", runs_completed, nr);
         check("rnd_done", done, 1'b1);
         check("rnd_err", err_timeout, 1'b0);
         check("rnd_pops", pops - pop0, nr);
      end

      // enable low clears sticky status synchronously
      enable = 1'b0; tick(1);
      check("en_done", done, 1'b0);
      check("en_valid", rd_valid, 1'b0);
      enable = 1'b1; tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
